fifo_wr_arbiter: RTL and testbench

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

---
 rtl/fifo_wr_arbiter.sv | 134 +++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-limited write arbiter that merges NREQ requesters onto one shared FIFO write port.
// Define FIFO_ARB_PRIO_EN to give requester 0 absolute priority with bursts not capped by BURST.
module fifo_wr_arbiter #(
   parameter int DWIDTH = 5,
   parameter int NREQ   = 4,
   parameter int BURST  = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NREQ-1:0]         req,
   input  logic [NREQ*DWIDTH-1:0]  wdata,
   output logic [NREQ-1:0]         gnt,
   input  logic                    full,
   output logic                    wr_en,
   output logic [DWIDTH-1:0]       data_in,
   output logic [$clog2(NREQ)-1:0] owner,
   output logic                    busy
);

   localparam int              OW          = $clog2(NREQ);
   localparam logic [7:0]      BURST_LIMIT = 8'(BURST);
   localparam logic [OW:0]     NREQ_W      = (OW+1)'(NREQ);
   localparam logic [OW-1:0]   LAST        = OW'(NREQ-1);

   typedef enum logic {S_IDLE, S_BURST} state_t;

   state_t        state, state_nxt;
   logic [OW-1:0] rr, rr_nxt, owner_nxt, pick, sel;
   logic [7:0]    bcnt, bcnt_nxt;
   logic          pick_vld, sel_vld, burst_done;
   logic [OW:0]   idx;

   // Scan offsets from far to near so the requester closest to rr is the last (winning) hit.
   always_comb begin
      pick     = '0;
      pick_vld = 1'b0;
      idx      = '0;
      for (int k = NREQ-1; k >= 0; k--) begin
         idx = {1'b0, rr} + (OW+1)'(k);
         if (idx >= NREQ_W) begin
            idx = idx - NREQ_W;
         end
         if (req[idx[OW-1:0]]) begin
            pick     = idx[OW-1:0];
            pick_vld = 1'b1;
         end
      end
`ifdef FIFO_ARB_PRIO_EN
      if (req[0]) begin
         pick     = '0;
         pick_vld = 1'b1;
      end
`endif
   end

   always_comb begin
      burst_done = (bcnt >= BURST_LIMIT);
`ifdef FIFO_ARB_PRIO_EN
      if (owner == '0) begin
         burst_done = 1'b0;
      end
`endif
   end

   // A full FIFO freezes everything, so stalled cycles never count toward the burst.
   always_comb begin
      state_nxt = state;
      rr_nxt    = rr;
      owner_nxt = owner;
      bcnt_nxt  = bcnt;
      sel       = '0;
      sel_vld   = 1'b0;
      if (!full) begin
         case (state)
            S_IDLE: begin
               if (pick_vld) begin
                  sel       = pick;
                  sel_vld   = 1'b1;
                  state_nxt = S_BURST;
                  owner_nxt = pick;
                  bcnt_nxt  = 8'd1;
               end
            end
            S_BURST: begin
               if (req[owner] && !burst_done) begin
                  sel     = owner;
                  sel_vld = 1'b1;
                  if (bcnt != 8'hFF) begin
                     bcnt_nxt = bcnt + 8'd1;
                  end
               end else begin
                  state_nxt = S_IDLE;
                  rr_nxt    = (owner == LAST) ? '0 : owner + OW'(1);
               end
            end
            default: begin
               state_nxt = S_IDLE;
            end
         endcase
      end
   end

   // Grants are gated by reset so nothing is written while rst is low, even before a clock edge.
   always_comb begin
      gnt     = '0;
      data_in = '0;
      if (sel_vld && rst) begin
         gnt[sel] = 1'b1;
      end
      for (int k = 0; k < NREQ; k++) begin
         if (gnt[k]) begin
            data_in = wdata[k*DWIDTH +: DWIDTH];
         end
      end
   end

   assign wr_en = |gnt;
   assign busy  = (state == S_BURST);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= S_IDLE;
         rr    <= '0;
         owner <= '0;
         bcnt  <= '0;
      end else begin
         state <= state_nxt;
         rr    <= rr_nxt;
         owner <= owner_nxt;
         bcnt  <= bcnt_nxt;
      end
   end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed scenarios plus random traffic against a burst/round-robin reference model.
// The shared FIFO (depth 256) is modelled as a queue; its full flag drives the arbiter.
module tb_fifo_wr_arbiter;

   localparam int DWIDTH = 5;
   localparam int NREQ   = 4;
   localparam int BURST  = 4;
   localparam int DEPTH  = 256;
   localparam int OW     = 2;

   logic                   clk = 1'b0;
   logic                   rst = 1'b1;
   logic [NREQ-1:0]        req = '0;
   logic [NREQ*DWIDTH-1:0] wdata = '0;
   logic [NREQ-1:0]        gnt;
   logic                   full = 1'b0;
   logic                   wr_en;
   logic [DWIDTH-1:0]      data_in;
   logic [OW-1:0]          owner;
   logic                   busy;

   int checks = 0;
   int errors = 0;

   logic [DWIDTH-1:0] fifo_q[$];

   bit m_busy;
   int m_owner;
   int m_writes;
   int m_rr;
   int wait_cnt[NREQ];

   fifo_wr_arbiter #(.DWIDTH(DWIDTH), .NREQ(NREQ), .BURST(BURST)) dut (
      .clk(clk), .rst(rst), .req(req), .wdata(wdata), .gnt(gnt), .full(full),
      .wr_en(wr_en), .data_in(data_in), .owner(owner), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
      end
   endtask

   task automatic modelReset();
      m_busy   = 1'b0;
      m_owner  = 0;
      m_writes = 0;
      m_rr     = 0;
      for (int i = 0; i < NREQ; i++) wait_cnt[i] = 0;
   endtask

   // Reset is asserted at a negedge with every requester active; outputs must clear without a clock.
   task automatic applyReset(input int cycles);
      @(negedge clk);
      rst   = 1'b0;
      req   = '1;
      full  = 1'b0;
      wdata = {4{5'd21}};
      #1;
      checkOutput("rst_gnt", gnt, 0);
      checkOutput("rst_wr_en", wr_en, 0);
      checkOutput("rst_data_in", data_in, 0);
      checkOutput("rst_busy", busy, 0);
      repeat (cycles) @(posedge clk);
      #1;
      checkOutput("rst_edge_wr_en", wr_en, 0);
      checkOutput("rst_edge_owner", owner, 0);
      @(negedge clk);
      rst = 1'b1;
      req = '0;
      modelReset();
   endtask

   // One clock cycle: drive inputs after a negedge, check against the model, then advance the model at posedge.
   task automatic applyStimulus(input logic [NREQ-1:0] r, input logic [NREQ*DWIDTH-1:0] wd,
                                input bit rd, input bit extra_full, output logic [NREQ-1:0] seen_gnt);
      int                exp_idx;
      bit                limit_ok;
      logic [NREQ-1:0]   exp_gnt;
      logic [DWIDTH-1:0] exp_data;
      logic              obs_wr;
      logic [DWIDTH-1:0] obs_data;
      req   = r;
      wdata = wd;
      full  = (fifo_q.size() >= DEPTH) || extra_full;
      #1;
      exp_idx  = -1;
      limit_ok = (m_writes < BURST);
`ifdef FIFO_ARB_PRIO_EN
      if (m_owner == 0) limit_ok = 1'b1;
`endif
      if (!full) begin
         if (!m_busy) begin
            for (int k = NREQ-1; k >= 0; k--) begin
               if (r[(m_rr + k) % NREQ]) exp_idx = (m_rr + k) % NREQ;
            end
`ifdef FIFO_ARB_PRIO_EN
            if (r[0]) exp_idx = 0;
`endif
         end else if (r[m_owner] && limit_ok) begin
            exp_idx = m_owner;
         end
      end
      exp_gnt  = '0;
      exp_data = '0;
      if (exp_idx >= 0) begin
         exp_gnt[exp_idx] = 1'b1;
         exp_data = wd[exp_idx*DWIDTH +: DWIDTH];
      end
      checkOutput("gnt", gnt, exp_gnt);
      checkOutput("wr_en", wr_en, (exp_idx >= 0) ? 1 : 0);
      checkOutput("data_in", data_in, exp_data);
      checkOutput("busy", busy, m_busy);
      if (m_busy) checkOutput("owner", owner, m_owner);
      if (exp_idx >= 0) begin
         for (int i = 0; i < NREQ; i++) begin
            if (i == exp_idx) begin
`ifdef FIFO_ARB_PRIO_EN
               if (i == 0) checkOutput("wait_bound", (wait_cnt[i] <= (NREQ-1)*BURST) ? 1 : 0, 1);
`else
               checkOutput("wait_bound", (wait_cnt[i] <= (NREQ-1)*BURST) ? 1 : 0, 1);
`endif
               wait_cnt[i] = 0;
            end else if (r[i]) begin
               wait_cnt[i]++;
            end
         end
      end
      for (int i = 0; i < NREQ; i++) if (!r[i]) wait_cnt[i] = 0;
      seen_gnt = gnt;
      obs_wr   = wr_en;
      obs_data = data_in;
      @(posedge clk);
      if (obs_wr) fifo_q.push_back(obs_data);
      if (rd && fifo_q.size() > 0) void'(fifo_q.pop_front());
      if (!full) begin
         if (!m_busy) begin
            if (exp_idx >= 0) begin
               m_busy   = 1'b1;
               m_owner  = exp_idx;
               m_writes = 1;
            end
         end else if (exp_idx >= 0) begin
            m_writes++;
         end else begin
            m_busy = 1'b0;
            m_rr   = (m_owner + 1) % NREQ;
         end
      end
      @(negedge clk);
   endtask

   initial begin
      logic [NREQ-1:0]        g;
      logic [6:0]             pat_single;
      logic [NREQ-1:0]        r_cur;
      logic [NREQ*DWIDTH-1:0] wd_cur;
      int                     writes;

      modelReset();
      applyReset(2);

      // Single requester: four grants, a gap cycle, then a fresh burst.
      fifo_q.delete();
      pat_single = 7'b1101111;
      for (int c = 0; c < 7; c++) begin
         applyStimulus(4'b0010, {4{5'd7}}, 1'b0, 1'b0, g);
         checkOutput("single_gnt", g, pat_single[c] ? 4'b0010 : 4'b0000);
      end
      applyStimulus(4'b0000, {4{5'd7}}, 1'b0, 1'b0, g);
      checkOutput("single_fifo_size", fifo_q.size(), 6);
      foreach (fifo_q[i]) checkOutput("single_fifo_data", fifo_q[i], 7);

      // Fairness: everyone requesting rotates owners 0,1,2,3,0 in bursts of four.
      applyReset(1);
      fifo_q.delete();
      for (int c = 0; c < 25; c++) begin
         applyStimulus(4'b1111, {5'd3, 5'd2, 5'd1, 5'd0}, 1'b0, 1'b0, g);
         checkOutput("fair_gnt", g, ((c % 5) == 4) ? 0 : (1 << ((c / 5) % NREQ)));
      end

      // Full stall: one write fills the FIFO, then nothing until one entry is read.
      applyReset(1);
      fifo_q.delete();
      for (int i = 0; i < DEPTH-1; i++) fifo_q.push_back(DWIDTH'(i));
      writes = 0;
      for (int c = 0; c < 8; c++) begin
         applyStimulus(4'b0001, {4{5'd9}}, (c == 4), 1'b0, g);
         if (g != 0) writes++;
         checkOutput("stall_gnt", g, (c == 0 || c == 5) ? 4'b0001 : 4'b0000);
      end
      checkOutput("stall_writes", writes, 2);
      checkOutput("stall_fifo_size", fifo_q.size(), DEPTH);
      applyStimulus(4'b0000, '0, 1'b0, 1'b0, g);

      // Early release: requester 2 drops after two grants, so requester 3 is next.
      applyReset(1);
      fifo_q.delete();
      applyStimulus(4'b0100, {4{5'd12}}, 1'b0, 1'b0, g);
      checkOutput("early_gnt0", g, 4'b0100);
      applyStimulus(4'b0100, {4{5'd12}}, 1'b0, 1'b0, g);
      checkOutput("early_gnt1", g, 4'b0100);
      applyStimulus(4'b1011, {4{5'd13}}, 1'b0, 1'b0, g);
      checkOutput("early_gap", g, 4'b0000);
      applyStimulus(4'b1011, {4{5'd13}}, 1'b0, 1'b0, g);
      checkOutput("early_next", g, 4'b1000);

      // Reset in the middle of a burst: no write, then arbitration restarts at requester 0.
      applyStimulus(4'b1000, {4{5'd13}}, 1'b0, 1'b0, g);
      applyReset(1);
      applyStimulus(4'b0110, {5'd1, 5'd2, 5'd3, 5'd4}, 1'b0, 1'b0, g);
      checkOutput("post_rst_gnt", g, 4'b0010);

`ifdef FIFO_ARB_PRIO_EN
      applyReset(1);
      fifo_q.delete();
      for (int c = 0; c < 10; c++) begin
         applyStimulus(4'b1001, {4{5'd5}}, 1'b0, 1'b0, g);
         checkOutput("prio_gnt", g, 4'b0001);
      end
`endif

      // Random traffic: requesters hold req and data until granted; FIFO drains and stalls randomly.
      applyReset(1);
      fifo_q.delete();
      r_cur  = '0;
      wd_cur = '0;
      repeat (600) begin
         for (int i = 0; i < NREQ; i++) begin
            if (!r_cur[i] && $urandom_range(0, 2) == 0) begin
               r_cur[i] = 1'b1;
               wd_cur[i*DWIDTH +: DWIDTH] = DWIDTH'($urandom);
            end
         end
         applyStimulus(r_cur, wd_cur, ($urandom_range(0, 1) == 1), ($urandom_range(0, 5) == 0), g);
         for (int i = 0; i < NREQ; i++) begin
            if (g[i]) begin
               if ($urandom_range(0, 3) == 0) r_cur[i] = 1'b0;
               else wd_cur[i*DWIDTH +: DWIDTH] = DWIDTH'($urandom);
            end
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
